// File: rtl/pipelined_shift_unit.sv
// Two-stage pipelined barrel shifter: SLL / SRL / SRA / ROL by a variable amount, with a passthrough tag.
// Latency: result on out_* right after the second rising edge counted from the accept edge; one op per cycle.
// Backpressure: valid/ready; a stalled output holds, stage 1 still fills, in_ready drops when both stages are full.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   flush                 synchronous flush of both stages (beats accept and advance)
//   in_valid/in_ready     input handshake; in_data, in_shamt, in_op, in_tag qualify in_valid
//   out_valid/out_ready   output handshake; out_data, out_tag come straight from stage-2 registers
//
// in_op encoding: 00 SLL, 01 SRL, 10 SRA, 11 ROL.

module pipelined_shift_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int SPLIT   = SHAMT_W / 2,
   parameter int TAG_W   = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // Number of shift-amount bits resolved in stage 1 (the upper ones).
   localparam int N_HI = SHAMT_W - SPLIT;

   // One barrel layer: shift x by a constant power of two in the selected mode.
   // SRA fills with an explicit sign bit so stage 2 can use the original operand's
   // sign rather than whatever the partial result's MSB happens to be.
   function automatic logic [WIDTH-1:0] shift_layer(
      input logic [WIDTH-1:0]   x,
      input logic [1:0]         op,
      input logic               fill,
      input logic [SHAMT_W-1:0] amt
   );
      logic [2*WIDTH-1:0] ext;
      logic [WIDTH-1:0]   r;
      ext = '0;
      r   = x;
      case (op)
         OP_SLL: r = x << amt;
         OP_SRL: r = x >> amt;
         OP_SRA: begin
            ext = {{WIDTH{fill}}, x} >> amt;
            r   = ext[WIDTH-1:0];
         end
         OP_ROL: begin
            // Upper half of {x,x} << amt is the left rotation of x.
            ext = {x, x} << amt;
            r   = ext[2*WIDTH-1:WIDTH];
         end
         default: r = x;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_data;
   logic [SPLIT-1:0]   s1_lo;
   logic [1:0]         s1_op;
   logic [TAG_W-1:0]   s1_tag;
   logic               s1_sign;

   logic               s2_valid;
   logic [WIDTH-1:0]   s2_data;
   logic [TAG_W-1:0]   s2_tag;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s2_adv;
   logic s1_adv;
   logic accept;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Stage 1 datapath: coarse shift by in_shamt[SHAMT_W-1:SPLIT] * 2^SPLIT
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] hi_chain [N_HI+1];

   assign hi_chain[0] = in_data;

   for (genvar g = 0; g < N_HI; g++) begin : g_hi_layer
      assign hi_chain[g+1] = in_shamt[SPLIT+g]
                           ? shift_layer(hi_chain[g], in_op, in_data[WIDTH-1], SHAMT_W'(2 ** (SPLIT + g)))
                           : hi_chain[g];
   end

   // ------------------------------------------------------------------
   // Stage 2 datapath: fine shift by the registered low amount bits
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] lo_chain [SPLIT+1];

   assign lo_chain[0] = s1_data;

   for (genvar g = 0; g < SPLIT; g++) begin : g_lo_layer
      assign lo_chain[g+1] = s1_lo[g]
                           ? shift_layer(lo_chain[g], s1_op, s1_sign, SHAMT_W'(2 ** g))
                           : lo_chain[g];
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_lo    <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
         s1_sign  <= 1'b0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_tag   <= '0;
      end else if (flush) begin
         // Payload registers keep stale contents; valids qualify them.
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         // Stage 2 takes whatever stage 1 holds in the same edge it drains.
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= lo_chain[SPLIT];
               s2_tag  <= s1_tag;
            end
         end
         if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
               s1_data <= hi_chain[N_HI];
               s1_lo   <= in_shamt[SPLIT-1:0];
               s1_op   <= in_op;
               s1_tag  <= in_tag;
               s1_sign <= in_data[WIDTH-1];
            end
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_data  = s2_data;
   assign out_tag   = s2_tag;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
module tb_pipelined_shift_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic [5:0]  in_shamt = '0;
   logic [1:0]  in_op = '0;
   logic [4:0]  in_tag = '0;

   logic        in_ready16, in_ready32, in_ready64;
   logic        out_valid16, out_valid32, out_valid64;
   logic [15:0] out_data16;
   logic [31:0] out_data32;
   logic [63:0] out_data64;
   logic [4:0]  out_tag16, out_tag32, out_tag64;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboards: {tag, data} in accept order.
   logic [68:0] q16[$];
   logic [68:0] q32[$];
   logic [68:0] q64[$];

   always #5 clock = ~clock;

   pipelined_shift_unit #(.WIDTH(16)) dut16 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready16),
      .in_data(in_data[15:0]), .in_shamt(in_shamt[3:0]), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_tag(out_tag16));

   pipelined_shift_unit #(.WIDTH(32)) dut32 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32),
      .in_data(in_data[31:0]), .in_shamt(in_shamt[4:0]), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32), .out_tag(out_tag32));

   pipelined_shift_unit #(.WIDTH(64)) dut64 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64), .out_tag(out_tag64));

   // Bit-by-bit reference shifter for width w.
   function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh, input logic [1:0] op, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (op)
            2'b00: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
            2'b01: r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
            2'b10: r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
            default: r[i] = d[(i - sh + w) % w];
         endcase
      end
      return r;
   endfunction

   // Sample the 32-bit DUT at the falling edge, then advance past the next rising edge.
   task automatic tick(output logic acc, output logic ov, output logic [31:0] od, output logic [4:0] ot);
      @(negedge clock);
      acc = in_valid && in_ready32;
      ov  = out_valid32;
      od  = out_data32;
      ot  = out_tag32;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      in_valid = 1'b1;
      in_data = 64'h0123_4567_89AB_CDEF;
      in_shamt = 6'd3;
      in_tag = 5'd7;
      out_ready = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++; if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid32); else n_pass++;
      n_checks++; if (out_data32 !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data32); else n_pass++;
      n_checks++; if (out_tag32 !== 5'h0) $display("FAIL reset_out_tag: got %h want 0", out_tag32); else n_pass++;
      n_checks++; if (out_valid16 !== 1'b0 || out_valid64 !== 1'b0)
         $display("FAIL reset_out_valid_w16_w64: got %b/%b want 0/0", out_valid16, out_valid64); else n_pass++;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready32); else n_pass++;
      n_checks++; if (out_valid32 !== 1'b0) $display("FAIL reset_idle_out_valid: got %b want 0", out_valid32); else n_pass++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_sll_latency;
      logic acc, ov;
      logic [31:0] od;
      logic [4:0] ot;
      logic [68:0] e;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 64'h0000_000F;
      in_shamt = 6'd4;
      in_op = 2'b00;
      in_tag = 5'd3;
      tick(acc, ov, od, ot);
      n_checks++; if (acc !== 1'b1) $display("FAIL lat_accept: got %b want 1", acc); else n_pass++;
      if (acc) q32.push_back({5'd3, 64'h0000_00F0});
      in_valid = 1'b0;
      tick(acc, ov, od, ot);
      n_checks++; if (ov !== 1'b0) $display("FAIL lat_early_valid: got %b want 0 one edge after accept", ov); else n_pass++;
      tick(acc, ov, od, ot);
      n_checks++; if (ov !== 1'b1) $display("FAIL lat_valid: got %b want 1 two edges after accept", ov); else n_pass++;
      if (ov && out_ready) begin
         if (q32.size() == 0) begin
            n_checks++; $display("FAIL lat_queue: got output, want none pending");
         end else begin
            e = q32.pop_front();
            n_checks++; if (od !== e[31:0]) $display("FAIL lat_data: got %h want %h", od, e[31:0]); else n_pass++;
            n_checks++; if (ot !== e[68:64]) $display("FAIL lat_tag: got %0d want %0d", ot, e[68:64]); else n_pass++;
         end
      end
      q32.delete();
   endtask

   task automatic test_modes;
      logic [31:0] t_d   [15] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_0000,
                                  32'h0000_000F, 32'h8000_0001, 32'h1234_5678, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                  32'hA5C3_0F96, 32'hA5C3_0F96, 32'h8000_F000, 32'h8000_0000, 32'hFFFF_FFFF};
      int          t_s   [15] = '{31, 31, 4, 5, 17, 17, 1, 16, 0, 0, 0, 0, 17, 31, 31};
      logic [1:0]  t_op  [15] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11,
                                  2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
      logic [31:0] t_exp [15] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h07FF_FFFF, 32'hFC00_0000, 32'h0000_4000,
                                  32'h001E_0000, 32'h0000_0003, 32'h5678_1234, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                  32'hA5C3_0F96, 32'hA5C3_0F96, 32'hFFFF_C000, 32'h4000_0000, 32'h8000_0000};
      logic acc, ov;
      logic [31:0] od;
      logic [4:0] ot;
      logic [68:0] e;
      int idx, done, cyc;
      idx = 0; done = 0; cyc = 0;
      out_ready = 1'b1;
      while (done < 15 && cyc < 60) begin
         if (idx < 15) begin
            in_valid = 1'b1;
            in_data  = {32'h0, t_d[idx]};
            in_shamt = 6'(t_s[idx]);
            in_op    = t_op[idx];
            in_tag   = 5'(idx);
         end else begin
            in_valid = 1'b0;
         end
         tick(acc, ov, od, ot);
         if (acc) begin
            q32.push_back({5'(idx), 32'h0, t_exp[idx]});
            idx++;
         end
         if (ov && out_ready) begin
            if (q32.size() == 0) begin
               n_checks++; $display("FAIL modes_queue: got unexpected output tag %0d", ot);
            end else begin
               e = q32.pop_front();
               n_checks++; if (od !== e[31:0]) $display("FAIL modes_data[%0d]: got %h want %h", e[68:64], od, e[31:0]); else n_pass++;
               n_checks++; if (ot !== e[68:64]) $display("FAIL modes_tag: got %0d want %0d", ot, e[68:64]); else n_pass++;
            end
            done++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (done != 15) $display("FAIL modes_timeout: got %0d results want 15", done); else n_pass++;
      q32.delete();
   endtask

   task automatic test_backpressure;
      logic acc, ov;
      logic [31:0] od, held_d;
      logic [4:0] ot, held_t;
      logic [68:0] e;
      int n_acc, done, cyc;
      n_acc = 0; done = 0; cyc = 0;
      held_d = '0; held_t = '0;
      while (done < 4 && cyc < 40) begin
         out_ready = (cyc >= 4);
         if (n_acc < 4) begin
            in_valid = 1'b1;
            in_data  = {32'h0, 28'hF00_0000, 4'(n_acc + 1)};
            in_shamt = 6'd4;
            in_op    = 2'b11;
            in_tag   = 5'(n_acc + 1);
         end else begin
            in_valid = 1'b0;
         end
         tick(acc, ov, od, ot);
         if (cyc == 2) begin
            n_checks++; if (acc !== 1'b0 || n_acc != 2)
               $display("FAIL bp_in_ready_fall: got accept=%b after %0d accepts want 0 after 2", acc, n_acc); else n_pass++;
            n_checks++; if (ov !== 1'b1) $display("FAIL bp_stall_valid: got %b want 1", ov); else n_pass++;
            held_d = od; held_t = ot;
         end
         if (cyc == 3) begin
            n_checks++; if (od !== held_d || ot !== held_t)
               $display("FAIL bp_stall_stable: got %h/%0d want %h/%0d", od, ot, held_d, held_t); else n_pass++;
            n_checks++; if (acc !== 1'b0) $display("FAIL bp_stall_in_ready: got %b want 0", acc); else n_pass++;
         end
         if (acc) begin
            q32.push_back({5'(n_acc + 1), 32'h0, 24'h0, 4'(n_acc + 1), 4'hF});
            n_acc++;
         end
         if (ov && out_ready) begin
            if (q32.size() == 0) begin
               n_checks++; $display("FAIL bp_queue: got unexpected output tag %0d", ot);
            end else begin
               e = q32.pop_front();
               n_checks++; if (od !== e[31:0]) $display("FAIL bp_data: got %h want %h", od, e[31:0]); else n_pass++;
               n_checks++; if (ot !== e[68:64]) $display("FAIL bp_order: got tag %0d want %0d", ot, e[68:64]); else n_pass++;
            end
            done++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (done != 4) $display("FAIL bp_count: got %0d results want 4", done); else n_pass++;
      q32.delete();
   endtask

   task automatic test_flush;
      logic acc, ov;
      logic [31:0] od;
      logic [4:0] ot;
      int n_acc, cyc, n_out;
      n_acc = 0; cyc = 0; n_out = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_op = 2'b00;
      in_shamt = 6'd1;
      while (n_acc < 2 && cyc < 10) begin
         in_data = 64'(n_acc + 5);
         in_tag  = 5'(n_acc + 5);
         tick(acc, ov, od, ot);
         if (acc) n_acc++;
         cyc++;
      end
      // Both stages full, flush with a new op presented.
      flush = 1'b1;
      in_tag = 5'd9;
      tick(acc, ov, od, ot);
      n_checks++; if (acc !== 1'b0) $display("FAIL flush_full_accept: got %b want 0", acc); else n_pass++;
      n_checks++; if (ov !== 1'b1) $display("FAIL flush_precondition_full: got out_valid %b want 1", ov); else n_pass++;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick(acc, ov, od, ot);
      n_checks++; if (ov !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", ov); else n_pass++;
      // Empty pipeline: flush alone must still block the presented op.
      flush = 1'b1;
      in_valid = 1'b1;
      tick(acc, ov, od, ot);
      n_checks++; if (acc !== 1'b0) $display("FAIL flush_empty_accept: got %b want 0", acc); else n_pass++;
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (4) begin
         tick(acc, ov, od, ot);
         if (ov) n_out++;
      end
      n_checks++; if (n_out != 0) $display("FAIL flush_leak: got %0d outputs want 0", n_out); else n_pass++;
      q32.delete();
   endtask

   task automatic test_reset_mid;
      logic acc, ov;
      logic [31:0] od;
      logic [4:0] ot;
      int n_out;
      n_out = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 64'hDEAD_BEEF;
      in_shamt = 6'd0;
      in_op = 2'b01;
      in_tag = 5'd12;
      repeat (3) tick(acc, ov, od, ot);
      n_checks++; if (out_valid32 !== 1'b1) $display("FAIL rstmid_precondition: got out_valid %b want 1", out_valid32); else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (out_valid32 !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid32); else n_pass++;
      n_checks++; if (out_data32 !== 32'h0) $display("FAIL rstmid_out_data: got %h want 0", out_data32); else n_pass++;
      n_checks++; if (out_tag32 !== 5'h0) $display("FAIL rstmid_out_tag: got %h want 0", out_tag32); else n_pass++;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         tick(acc, ov, od, ot);
         if (ov) n_out++;
      end
      n_checks++; if (n_out != 0) $display("FAIL rstmid_partial_output: got %0d outputs want 0", n_out); else n_pass++;
      q32.delete();
   endtask

   task automatic test_random;
      logic [68:0] e;
      int n_acc, cyc, n_fail_print;
      n_acc = 0; cyc = 0; n_fail_print = 0;
      reset_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      q16.delete(); q32.delete(); q64.delete();
      while ((n_acc < 10000 || q16.size() + q32.size() + q64.size() != 0) && cyc < 40000) begin
         if (n_acc < 10000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         in_data  = {$urandom, $urandom};
         in_shamt = 6'($urandom);
         in_op    = 2'($urandom);
         in_tag   = 5'($urandom);
         @(negedge clock);
         if (in_valid && in_ready16) q16.push_back({in_tag, ref_shift({48'h0, in_data[15:0]}, int'(in_shamt[3:0]), in_op, 16)});
         if (in_valid && in_ready32) begin
            q32.push_back({in_tag, ref_shift({32'h0, in_data[31:0]}, int'(in_shamt[4:0]), in_op, 32)});
            n_acc++;
         end
         if (in_valid && in_ready64) q64.push_back({in_tag, ref_shift(in_data, int'(in_shamt), in_op, 64)});
         if (out_valid16 && out_ready) begin
            e = (q16.size() != 0) ? q16.pop_front() : {5'h1F, 64'hX};
            n_checks++;
            if (out_data16 !== e[15:0] || out_tag16 !== e[68:64]) begin
               if (n_fail_print < 20) $display("FAIL rand16: got %h/%0d want %h/%0d", out_data16, out_tag16, e[15:0], e[68:64]);
               n_fail_print++;
            end else n_pass++;
         end
         if (out_valid32 && out_ready) begin
            e = (q32.size() != 0) ? q32.pop_front() : {5'h1F, 64'hX};
            n_checks++;
            if (out_data32 !== e[31:0] || out_tag32 !== e[68:64]) begin
               if (n_fail_print < 20) $display("FAIL rand32: got %h/%0d want %h/%0d", out_data32, out_tag32, e[31:0], e[68:64]);
               n_fail_print++;
            end else n_pass++;
         end
         if (out_valid64 && out_ready) begin
            e = (q64.size() != 0) ? q64.pop_front() : {5'h1F, 64'hX};
            n_checks++;
            if (out_data64 !== e[63:0] || out_tag64 !== e[68:64]) begin
               if (n_fail_print < 20) $display("FAIL rand64: got %h/%0d want %h/%0d", out_data64, out_tag64, e[63:0], e[68:64]);
               n_fail_print++;
            end else n_pass++;
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (n_acc != 10000) $display("FAIL rand_accepts: got %0d want 10000", n_acc); else n_pass++;
      n_checks++; if (q16.size() + q32.size() + q64.size() != 0)
         $display("FAIL rand_drain: got %0d/%0d/%0d pending want 0", q16.size(), q32.size(), q64.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sll_latency();
      test_modes();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
- Parametrised successor to the fixed single-mode shifter: a WIDTH-bit, two-stage pipelined barrel shifter for the execute stage.
- Supports four modes: logical left, logical right, arithmetic right and rotate left. The shift amount is variable.
- Uses a valid/ready handshake with backpressure. Carries an opaque tag so the issuing pipeline can match results.
- Sustains one operation per cycle with a fixed latency of 2 clock edges.

Parameters:
- WIDTH, 32, data width; must be a power of two and at least 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; not overridden.
- SPLIT, SHAMT_W/2, number of low shift-amount bits resolved in stage 2. Stage 1 resolves bits [SHAMT_W-1:SPLIT].
- TAG_W, 5, width of the passthrough tag (destination register index).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  an operation is presented this cycle.
- in_ready  out  1  the unit accepts an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- in_op  in  2  mode: 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROL.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset:
  - reset_n low immediately clears s1_valid, s2_valid, and all data, tag, op and shamt registers to 0.
  - Consequently out_valid = 0, out_data = 0 and out_tag = 0 while reset is held.
  - Reset asserted mid-operation discards all in-flight operations; there is no partial output.
- Arithmetic, per mode:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with in_data[WIDTH-1].
  - ROL: bits leaving the MSB re-enter at the LSB.
  - shamt = 0 returns in_data unchanged in every mode.
  - No amount is out of range: SHAMT_W bits cover 0..WIDTH-1 exactly.
- Stage split:
  - Stage 1 applies the shift by in_shamt[SHAMT_W-1:SPLIT]·2^SPLIT and registers the partial result, the low shamt bits, op, tag and the original sign bit.
  - Stage 2 applies the remaining low bits. SRA fill in stage 2 uses the registered original sign bit, not the partial MSB.
  - The result is bit-exact to a single-cycle shift.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush.
  - Accept occurs when in_valid && in_ready.
  - Stage 1 loads on s1_adv: s1_valid <= accept.
  - Stage 2 loads on s2_adv: s2_valid <= s1_valid.
  - out_valid = s2_valid. out_data and out_tag come directly from stage-2 registers, with no combinational path from inputs.
- Latency and throughput:
  - An operation accepted at edge N is presented on out_* immediately after edge N+1 (two edges from accept, counting the accept edge).
  - Throughput is 1 per cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, out_data and out_tag are held stable.
  - Stage 1 may still fill if empty. in_ready falls once both stages hold operations.
  - Order is preserved; no operation is dropped or duplicated.
- Simultaneous events:
  - A new accept together with out_ready high in the same cycle moves both stages forward in one edge.
  - An operation sitting in stage 1 moves into stage 2 in the same edge that stage 2 drains.
- Flush:
  - flush high at an edge clears s1_valid and s2_valid. Flush has priority over accept and over any advance.
  - in_ready is 0 during the flush cycle. Data registers may retain stale values but are qualified by valid.
- Inputs are ignored when in_valid = 0. The tag is never interpreted.

Test Plan:
- SLL 0x0000000F by 4, tag 3, out_ready = 1 → out_valid exactly 2 edges after accept; out_data = 0x000000F0, out_tag = 3.
- Sign handling on 0x80000000 by 31:
  - SRA → 0xFFFFFFFF.
  - SRL → 0x00000001.
  - SRA of 0x7FFFFFF0 by 4 → 0x07FFFFFF.
  - Amounts 5 and 17 exercise both stages.
- ROL 0x80000001 by 1 → 0x00000003. ROL 0x12345678 by 16 → 0x56781234. Each of the 4 modes with shamt 0 → operand unchanged.
- Backpressure: issue 4 back-to-back ops with tags 1..4 while out_ready is held low 3 cycles → in_ready falls after 2 accepts; out_data is stable while stalled; results then appear in tag order 1,2,3,4 with none lost.
- Flush with both stages full and in_valid high → next cycle out_valid = 0 and the presented op is not accepted. Separately, assert reset_n low between edges mid-stream → out_valid and out_data go to 0 immediately.
- Constrained-random 10k ops (random op, shamt, data, in_valid, out_ready) against a behavioural model → every result and tag matches, in order; repeat at WIDTH = 16 and WIDTH = 64.
